serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's adder blocks. It trades latency for area: one 1-bit cell is reused WIDTH times. A start/busy/done handshake lets a controller or testbench launch an operation and wait for completion.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the column needs a borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one full-subtractor cell reused WIDTH times.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             d_bit;
  logic             br_next;
  logic             accept;
  logic             last_shift;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  // The result register holds only the WIDTH-1 bits already produced; the
  // current cell output completes the word on the final shift edge.
  assign res_next   = {d_bit, res_sr};
  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_shift = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          cnt <= cnt + 1'b1;
          br  <= br_next;
          if (last_shift) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= br_next;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the operand and result shift registers carry no reset; they are
  // always loaded on accept before being read, so a reset would only cost area.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= a;
      b_sr <= b;
    end else if (state == S_SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next[WIDTH-1:1];
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed cases plus a random sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit prev_done = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: unsigned difference with a borrow flag.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    logic [W-1:0] d;
    r = int'(x) - int'(y);
    d = r[W-1:0];
    return {(x < y), d};
  endfunction

  // Count done pulses; with no back-to-back closer than W+1 cycles, done never repeats.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("no_consec_done", prev_done, 0);
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, check its timing, return the observed result.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input string tag,
                        output logic [W-1:0] got_d, output logic got_b);
    int lat;
    int busy_n;
    bit seen;
    a = oa;
    b = ob;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_latency"}, lat, W + 1);
    check({tag, "_busy_cycles"}, busy_n, W);
    got_d = diff;
    got_b = borrow;
    tick();
    check({tag, "_done_single"}, done, 0);
  endtask

  logic [W-1:0] gd;
  logic         gb;
  logic [W:0]   exp_v;
  logic [W-1:0] ra, rb;
  int           snap;
  int           gap;
  bit           seen2;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    rst = 1'b0;
    tick();

    run_op(8'd200, 8'd55, "d200_55", gd, gb);
    check("d200_55_diff", gd, 145);
    check("d200_55_borrow", gb, 0);
    run_op(8'd55, 8'd200, "d55_200", gd, gb);
    check("d55_200_diff", gd, 111);
    check("d55_200_borrow", gb, 1);
    run_op(8'd0, 8'd1, "d0_1", gd, gb);
    check("d0_1_diff", gd, 255);
    check("d0_1_borrow", gb, 1);
    // Outputs hold their last value while idle.
    tick();
    check("hold_diff", diff, 255);
    check("hold_borrow", borrow, 1);
    run_op(8'h5A, 8'h5A, "d5a_5a", gd, gb);
    check("d5a_5a_diff", gd, 0);
    check("d5a_5a_borrow", gb, 0);

    // start during busy is ignored
    snap = done_cnt;
    a = 8'd200; b = 8'd55; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", busy, 1);
    seen2 = 1'b0;
    for (int k = 0; k < 20 && !seen2; k++) begin
      if (done) seen2 = 1'b1;
      else tick();
    end
    check("ign_seen", seen2, 1);
    check("ign_diff", diff, 145);
    check("ign_borrow", borrow, 0);
    for (int k = 0; k < 12; k++) tick();
    check("ign_one_done", done_cnt - snap, 1);

    // Reset mid-operation
    a = 8'd77; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    snap = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_diff", diff, 0);
    check("mrst_borrow", borrow, 0);
    check("mrst_done", done, 0);
    for (int k = 0; k < 12; k++) tick();
    check("mrst_no_done", done_cnt - snap, 0);
    run_op(8'd10, 8'd3, "d10_3", gd, gb);
    check("d10_3_diff", gd, 7);
    check("d10_3_borrow", gb, 0);

    // Back-to-back
    a = 8'd100; b = 8'd1; start = 1'b1;
    tick();
    seen2 = 1'b0;
    for (int k = 0; k < 20 && !seen2; k++) begin
      if (done) seen2 = 1'b1;
      else tick();
    end
    check("b2b_first_seen", seen2, 1);
    check("b2b_first_diff", diff, 99);
    check("b2b_first_borrow", borrow, 0);
    a = 8'd1; b = 8'd100;
    tick();
    start = 1'b0;
    gap = 1;
    check("b2b_relaunch_busy", busy, 1);
    seen2 = 1'b0;
    for (int k = 0; k < 20 && !seen2; k++) begin
      if (done) seen2 = 1'b1;
      else begin
        tick();
        gap++;
      end
    end
    check("b2b_second_seen", seen2, 1);
    check("b2b_gap", gap, W + 1);
    check("b2b_second_diff", diff, 157);
    check("b2b_second_borrow", borrow, 1);
    tick();

    // Random sweep against the arithmetic model
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      exp_v = model(ra, rb);
      run_op(ra, rb, "rand", gd, gb);
      check("rand_result", {gb, gd}, exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
